// File: rtl/enc_stream.sv
// rtl/enc_stream.sv - two-stage encrypt/hash pipeline with credit-gated output FIFO; frame digest under ENC_STREAM_DIGEST_EN
module encrypt (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    logic [7:0] t;
    assign t    = din ^ 8'hA5;
    assign dout = {t[4:0], t[7:5]} + 8'h3C;
endmodule

module hash (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    assign dout = din ^ {din[5:0], 2'b00} ^ {3'b000, din[7:3]} ^ 8'h96;
endmodule

module enc_stream #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       plain_valid,
    output logic       plain_ready,
    input  logic [7:0] plain_data,
    input  logic       plain_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_enc,
    output logic [7:0] out_hash,
    output logic       out_last,
    output logic [7:0] out_len,
    output logic [7:0] out_digest
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
`ifdef ENC_STREAM_DIGEST_EN
    localparam int EW = 33;
`else
    localparam int EW = 25;
`endif

    logic          run;
    logic [7:0]    len_cnt;
    logic          s1_valid, s1_last;
    logic [7:0]    s1_enc, s1_len;
    logic          s2_valid, s2_last;
    logic [7:0]    s2_enc, s2_hash, s2_len;
    logic [7:0]    enc_c, hash_c;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [CW+1:0] inflight;
    logic          accept, pop, push;
    logic [EW-1:0] s2_entry, rd_entry;
    logic [EW-1:0] mem [FIFO_DEPTH];

    encrypt u_encrypt (.din(plain_data), .dout(enc_c));
    hash    u_hash    (.din(s1_enc),     .dout(hash_c));

    // Credits cover every byte already past the input so the FIFO can always absorb S2.
    assign inflight    = (CW+2)'(count) + (CW+2)'(s1_valid) + (CW+2)'(s2_valid);
    assign plain_ready = run && (inflight < (CW+2)'(FIFO_DEPTH));
    assign accept      = plain_valid && plain_ready;
    assign push        = s2_valid;
    assign out_valid   = (count != '0);
    assign pop         = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            len_cnt  <= 8'd0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_enc   <= 8'd0;
            s1_len   <= 8'd0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_enc   <= 8'd0;
            s2_hash  <= 8'd0;
            s2_len   <= 8'd0;
        end else begin
            run      <= 1'b1;
            s1_valid <= accept;
            if (accept) begin
                s1_enc  <= enc_c;
                s1_last <= plain_last;
                s1_len  <= len_cnt + 8'd1;
                len_cnt <= plain_last ? 8'd0 : len_cnt + 8'd1;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_enc  <= s1_enc;
                s2_hash <= hash_c;
                s2_last <= s1_last;
                s2_len  <= s1_len;
            end
        end
    end

`ifdef ENC_STREAM_DIGEST_EN
    logic [7:0] dig_acc, s2_digest;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_acc   <= 8'd0;
            s2_digest <= 8'd0;
        end else if (s1_valid) begin
            s2_digest <= dig_acc ^ hash_c;
            dig_acc   <= s1_last ? 8'd0 : (dig_acc ^ hash_c);
        end
    end

    assign s2_entry   = {s2_digest, s2_last, s2_len, s2_hash, s2_enc};
    assign out_digest = out_valid ? rd_entry[32:25] : 8'd0;
`else
    assign s2_entry   = {s2_last, s2_len, s2_hash, s2_enc};
    assign out_digest = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s2_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Outputs are forced to zero whenever nothing is buffered, which also covers reset.
    assign rd_entry = mem[rd_ptr];
    assign out_enc  = out_valid ? rd_entry[7:0]   : 8'd0;
    assign out_hash = out_valid ? rd_entry[15:8]  : 8'd0;
    assign out_len  = out_valid ? rd_entry[23:16] : 8'd0;
    assign out_last = out_valid ? rd_entry[24]    : 1'b0;
endmodule

// File: tb/tb_enc_stream.sv
// tb/tb_enc_stream.sv - randomized scoreboard bench for enc_stream
module tb_enc_stream;
    localparam int DEPTH = 4;
`ifdef ENC_STREAM_DIGEST_EN
    localparam bit DIG_EN = 1'b1;
`else
    localparam bit DIG_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] enc;
        logic [7:0] hash;
        logic       last;
        logic [7:0] len;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       plain_valid = 1'b0;
    logic       plain_ready;
    logic [7:0] plain_data = 8'd0;
    logic       plain_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_enc, out_hash, out_len, out_digest;
    logic       out_last;

    int errors = 0;
    int checks = 0;

    beat_t      exp_q[$];
    logic [7:0] dig_q[$];
    logic [7:0] plain_q[$];
    int         m_len = 0;
    int         m_acc = 0;

    enc_stream #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .plain_valid(plain_valid), .plain_ready(plain_ready),
        .plain_data(plain_data), .plain_last(plain_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_enc(out_enc), .out_hash(out_hash), .out_last(out_last),
        .out_len(out_len), .out_digest(out_digest)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] enc_f(input logic [7:0] p);
        int x;
        x = int'(p) ^ 165;
        x = ((x * 8) + (x / 32)) % 256;
        return 8'((x + 60) % 256);
    endfunction

    function automatic logic [7:0] dec_f(input logic [7:0] c);
        int x;
        x = (int'(c) + 256 - 60) % 256;
        x = ((x / 8) + (x * 32)) % 256;
        return 8'(x ^ 165);
    endfunction

    function automatic logic [7:0] hash_f(input logic [7:0] e);
        int x;
        x = int'(e);
        return 8'((x ^ (x * 4) ^ (x / 8) ^ 150) % 256);
    endfunction

    task automatic model_clear();
        exp_q.delete();
        dig_q.delete();
        plain_q.delete();
        m_len = 0;
        m_acc = 0;
    endtask

    // Drive one cycle's inputs, record handshakes, and extend the expected stream on acceptance.
    task automatic step(input bit pv, input logic [7:0] pd, input bit pl, input bit ordy,
                        output bit acc, output bit popped, output beat_t got, output logic [7:0] got_dig);
        beat_t e;
        @(negedge clk);
        plain_valid = pv;
        plain_data  = pd;
        plain_last  = pl;
        out_ready   = ordy;
        #1;
        acc     = plain_valid && plain_ready;
        popped  = out_valid && out_ready;
        got     = '{enc: out_enc, hash: out_hash, last: out_last, len: out_len};
        got_dig = out_digest;
        if (acc) begin
            m_len  = (m_len + 1) % 256;
            e.enc  = enc_f(pd);
            e.hash = hash_f(e.enc);
            e.last = pl;
            e.len  = 8'(m_len);
            m_acc  = m_acc ^ int'(e.hash);
            exp_q.push_back(e);
            dig_q.push_back(DIG_EN ? 8'(m_acc) : 8'd0);
            plain_q.push_back(pd);
            if (pl) begin
                m_len = 0;
                m_acc = 0;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        plain_valid = 1'b0;
        out_ready = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        checks++;
        if (plain_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake got ready=%b valid=%b want 0 0", plain_ready, out_valid);
        end
        checks++;
        if ({out_enc, out_hash, out_last, out_len, out_digest} !== 33'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h/%h/%b/%h/%h want all 0", out_enc, out_hash, out_last, out_len, out_digest);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (plain_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got %b want 0", plain_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (plain_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_first_edge got %b want 1", plain_ready);
        end
        model_clear();
    endtask

    task automatic test_single_byte();
        bit acc, popped;
        beat_t got, e;
        logic [7:0] gd, d, p;
        int lat;
        step(1'b1, 8'h00, 1'b1, 1'b1, acc, popped, got, gd);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL single_accept got %b want 1", acc);
        end
        lat = -1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1, acc, popped, got, gd);
            if (popped) begin
                if (lat < 0) lat = i;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL single_extra_beat got enc=%h", got.enc);
                end else begin
                    e = exp_q.pop_front();
                    d = dig_q.pop_front();
                    p = plain_q.pop_front();
                    if (got !== e || (got.len !== 8'd1) || (got.last !== 1'b1)) begin
                        errors++;
                        $display("FAIL single_beat got %h want %h (plain %h)", got, e, p);
                    end
                    checks++;
                    if (gd !== d) begin
                        errors++;
                        $display("FAIL single_digest got %h want %h", gd, d);
                    end
                end
            end
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL single_latency got %0d want 2 edges after accept edge", lat);
        end
    endtask

    task automatic test_backpressure();
        bit acc, popped;
        beat_t got, e;
        logic [7:0] gd, d, p;
        int accepted, pops, first_pop, last_pop;
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, acc, popped, got, gd);
            if (acc) accepted++;
        end
        checks++;
        if (accepted !== DEPTH) begin
            errors++;
            $display("FAIL bp_accept_count got %0d want %0d", accepted, DEPTH);
        end
        #1;
        checks++;
        if (plain_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_low got %b want 0", plain_ready);
        end
        pops = 0;
        first_pop = -1;
        last_pop = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1, acc, popped, got, gd);
            if (popped) begin
                pops++;
                if (first_pop < 0) first_pop = i;
                last_pop = i;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra_beat got enc=%h", got.enc);
                end else begin
                    e = exp_q.pop_front();
                    d = dig_q.pop_front();
                    p = plain_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL bp_beat got %h want %h (plain %h)", got, e, p);
                    end
                end
            end
        end
        checks++;
        if (pops !== DEPTH || (last_pop - first_pop) !== DEPTH - 1) begin
            errors++;
            $display("FAIL bp_drain got pops=%0d span=%0d want %0d span=%0d", pops, last_pop - first_pop, DEPTH, DEPTH - 1);
        end
    endtask

    task automatic test_streaming();
        bit acc, popped;
        beat_t got, e;
        logic [7:0] gd, d, p, pd;
        int sent, pops, stalls, gaps, cyc;
        do_reset();
        sent = 0; pops = 0; stalls = 0; gaps = 0; cyc = 0;
        pd = 8'($urandom_range(0, 255));
        while ((sent < 256 || pops < 256) && cyc < 400) begin
            cyc++;
            step(sent < 256, pd, sent == 255, 1'b1, acc, popped, got, gd);
            if (sent < 256 && !acc) stalls++;
            if (acc) begin
                sent++;
                pd = 8'($urandom_range(0, 255));
            end
            if (pops > 0 && pops < 256 && !popped) gaps++;
            if (popped) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra_beat got enc=%h", got.enc);
                end else begin
                    e = exp_q.pop_front();
                    d = dig_q.pop_front();
                    p = plain_q.pop_front();
                    if (got !== e || dec_f(got.enc) !== p) begin
                        errors++;
                        $display("FAIL stream_beat %0d got %h want %h dec=%h plain=%h", pops, got, e, dec_f(got.enc), p);
                    end
                    if (e.last || !DIG_EN) begin
                        checks++;
                        if (gd !== d) begin
                            errors++;
                            $display("FAIL stream_digest got %h want %h", gd, d);
                        end
                    end
                    if (pops == 256) begin
                        checks++;
                        if (got.len !== 8'd0 || got.last !== 1'b1) begin
                            errors++;
                            $display("FAIL stream_wrap got len=%h last=%b want 00 1", got.len, got.last);
                        end
                    end
                end
            end
        end
        checks++;
        if (pops !== 256 || stalls !== 0 || gaps !== 0) begin
            errors++;
            $display("FAIL stream_rate got pops=%0d stalls=%0d gaps=%0d want 256 0 0", pops, stalls, gaps);
        end
    endtask

    task automatic test_digest();
        bit acc, popped;
        beat_t got, e;
        logic [7:0] gd, d, p, want;
        logic [7:0] bytes [3];
        int idx, nb;
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
        want = DIG_EN ? (hash_f(enc_f(8'h01)) ^ hash_f(enc_f(8'h02)) ^ hash_f(enc_f(8'h03))) : 8'h00;
        idx = 0; nb = 0;
        for (int i = 0; i < 20; i++) begin
            step(idx < 3, (idx < 3) ? bytes[idx] : 8'h00, idx == 2, 1'b1, acc, popped, got, gd);
            if (acc) idx++;
            if (popped) begin
                nb++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL digest_extra_beat got enc=%h", got.enc);
                end else begin
                    e = exp_q.pop_front();
                    d = dig_q.pop_front();
                    p = plain_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL digest_beat got %h want %h (plain %h)", got, e, p);
                    end
                end
                if (nb == 3) begin
                    checks++;
                    if (gd !== want || got.last !== 1'b1) begin
                        errors++;
                        $display("FAIL digest_value got %h last=%b want %h 1", gd, got.last, want);
                    end
                end
            end
        end
        checks++;
        if (nb !== 3) begin
            errors++;
            $display("FAIL digest_beats got %0d want 3", nb);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit acc, popped;
        beat_t got, e;
        logic [7:0] gd, d, p, want_dig;
        int nb, sent;
        step(1'b1, 8'h11, 1'b0, 1'b0, acc, popped, got, gd);
        step(1'b1, 8'h22, 1'b0, 1'b0, acc, popped, got, gd);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc, popped, got, gd);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        plain_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || plain_ready !== 1'b0 || out_len !== 8'd0) begin
            errors++;
            $display("FAIL midreset_outputs got valid=%b ready=%b len=%h want 0 0 00", out_valid, plain_ready, out_len);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        want_dig = DIG_EN ? hash_f(enc_f(8'h5A)) : 8'h00;
        nb = 0; sent = 0;
        for (int i = 0; i < 10; i++) begin
            step(sent == 0, 8'h5A, 1'b1, 1'b1, acc, popped, got, gd);
            if (acc) sent++;
            if (popped) begin
                nb++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL midreset_extra_beat got enc=%h len=%h", got.enc, got.len);
                end else begin
                    e = exp_q.pop_front();
                    d = dig_q.pop_front();
                    p = plain_q.pop_front();
                    if (got !== e || got.len !== 8'd1 || gd !== want_dig) begin
                        errors++;
                        $display("FAIL midreset_beat got %h dig=%h want %h dig=%h (plain %h)", got, gd, e, want_dig, p);
                    end
                end
            end
        end
        checks++;
        if (nb !== 1) begin
            errors++;
            $display("FAIL midreset_beat_count got %0d want 1", nb);
        end
    endtask

    task automatic test_random_backpressure();
        bit acc, popped;
        beat_t got, e;
        logic [7:0] gd, d, p, pd;
        bit pl, pv;
        int sent, pops, cyc;
        sent = 0; pops = 0; cyc = 0;
        pd = 8'($urandom_range(0, 255));
        pl = ($urandom_range(0, 7) == 0);
        while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
            cyc++;
            pv = (sent < 1000) && ($urandom_range(0, 3) != 0);
            step(pv, pd, pl, $urandom_range(0, 1) == 1, acc, popped, got, gd);
            if (acc) begin
                sent++;
                pd = 8'($urandom_range(0, 255));
                pl = ($urandom_range(0, 7) == 0);
            end
            if (popped) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra_beat got enc=%h", got.enc);
                end else begin
                    e = exp_q.pop_front();
                    d = dig_q.pop_front();
                    p = plain_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL rand_beat %0d got %h want %h (plain %h)", pops, got, e, p);
                    end
                    if (e.last || !DIG_EN) begin
                        checks++;
                        if (gd !== d) begin
                            errors++;
                            $display("FAIL rand_digest got %h want %h", gd, d);
                        end
                    end
                end
            end
        end
        checks++;
        if (pops !== 1000 || sent !== 1000 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL rand_totals got sent=%0d pops=%0d left=%0d want 1000 1000 0", sent, pops, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_backpressure();
        test_streaming();
        test_digest();
        test_reset_mid_frame();
        test_random_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/enc_stream.md
ENC_STREAM -- requirements
Module: enc_stream

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port plain_valid  input  1  plaintext byte offered.
REQ-005 SHALL have port plain_ready  output  1  block accepts byte this cycle.
REQ-006 SHALL have port plain_data  input  8  plaintext byte.
REQ-007 SHALL have port plain_last  input  1  byte closes current frame.
REQ-008 SHALL have port out_valid  output  1  output beat available.
REQ-009 SHALL have port out_ready  input  1  downstream (verify stage) consumes beat.
REQ-010 SHALL have port out_enc  output  8  ciphertext = encrypt(plain_data).
REQ-011 SHALL have port out_hash  output  8  hash(out_enc).
REQ-012 SHALL have port out_last  output  1  frame-closing beat.
REQ-013 SHALL have port out_len  output  8  byte index within frame, 1-based, modulo 256.
REQ-014 SHALL have port out_digest  output  8  frame digest, meaningful only when out_last=1.

Function
REQ-015 SHALL transfer input when plain_valid & plain_ready on rising clk; output pops when out_valid & out_ready.
REQ-016 SHALL reuse the existing encrypt and hash modules as the combinational cores; no alternative cipher logic.
REQ-017 SHALL pipeline: stage S1 registers encrypt result, stage S2 registers hash result, then FIFO; each stage carries a valid bit, last, len.
REQ-018 SHALL give latency 2 cycles: byte accepted at edge N appears on out_valid after edge N+2 when FIFO empty.
REQ-019 SHALL drive plain_ready = (fifo_count + S1 valid + S2 valid) < FIFO_DEPTH (credit scheme; FIFO never overflows, pipeline never stalls).
REQ-020 SHALL sustain one beat per cycle while out_ready held high.
REQ-021 SHALL hold out_enc/out_hash/out_last/out_len/out_digest stable while out_valid=1 and out_ready=0.
REQ-022 SHALL write FIFO from S2 and pop to output in the same cycle without loss when FIFO is full-minus-one or empty.
REQ-023 SHALL increment frame length counter per accepted byte, wrap 255->0 (next beat reports 0), reset to 0 after accepting a plain_last byte.
REQ-024 SHALL treat plain_last on frame's first byte as a 1-byte frame (out_len=1, out_last=1).
REQ-025 SHALL ignore plain_data/plain_last when plain_valid=0 or plain_ready=0.

Reset
REQ-026 SHALL on rst_n low clear S1/S2 valid, FIFO pointers/count, length counter, digest accumulator immediately, irrespective of clk.
REQ-027 SHALL during reset drive plain_ready=0, out_valid=0, out_enc=0, out_hash=0, out_last=0, out_len=0, out_digest=0.
REQ-028 SHALL drop any in-flight or buffered bytes on reset mid-frame; first byte after release starts a new frame with out_len=1.
REQ-029 SHALL assert plain_ready on first clk edge after rst_n deasserts.

Configuration
REQ-030 SHALL compile frame digest logic only when ENC_STREAM_DIGEST_EN is defined.
REQ-031 SHALL with ENC_STREAM_DIGEST_EN: out_digest on last beat = XOR of out_hash of all beats of that frame; accumulator cleared after last byte passes S2.
REQ-032 SHALL without ENC_STREAM_DIGEST_EN: out_digest tied 0, no accumulator registers.

Verification
REQ-033 SHALL cover single byte: plain_data=00, plain_last=1, out_ready=1 -> out_valid after 2 edges, out_enc=encrypt(00), out_hash=hash(encrypt(00)), out_len=1, out_last=1.
REQ-034 SHALL cover backpressure: out_ready=0, push 10 bytes continuously -> exactly FIFO_DEPTH (4) accepted, plain_ready=0 after; release out_ready -> 4 beats in order, no loss.
REQ-035 SHALL cover streaming: 256 random bytes, out_ready=1, one last on byte 256 -> 256 beats, one per cycle, out_len 1..255 then 0, each out_enc/out_hash matches decrypt/encrypt/hash gold models; verify stage reports valid_flag, enc_match, hash_match all 1.
REQ-036 SHALL cover digest (macro defined): frame bytes 01,02,03 -> out_digest on third beat = hash(e01)^hash(e02)^hash(e03); macro undefined -> out_digest=0.
REQ-037 SHALL cover reset mid-frame: 2 bytes of 3-byte frame in flight, rst_n low one cycle -> out_valid=0 immediately, next accepted byte gives out_len=1, digest restarts.
REQ-038 SHALL cover random out_ready toggling 50% over 1000 bytes -> output sequence equals input order, zero overflow, zero duplicated beats.
